// File: rtl/pulse_train_ctrl.sv
// pulse_train_ctrl: programmable single/double pulse train sequencer.
// One down-counter is reloaded on every state change. sig_out is a registered
// copy of "FSM is in a HIGH state", so it lags the FSM by one cycle. Because of
// that lag, a pulse starts one edge after HIGH1 is entered, and a stop seen at
// the end of a HIGH state still leaves the final high cycle intact.
module pulse_train_ctrl #(
   parameter int               CNT_W        = 16,
   parameter logic [CNT_W-1:0] DEF_DELAY    = CNT_W'(0),
   parameter logic [CNT_W-1:0] DEF_PERIOD   = CNT_W'(100),
   parameter logic [CNT_W-1:0] DEF_WIDTH    = CNT_W'(2),
   parameter logic [CNT_W-1:0] DEF_INTERVAL = CNT_W'(5)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [CNT_W-1:0] cfg_interval,
   input  logic             cfg_double,
   output logic             cfg_err,
   input  logic             start,
   input  logic             stop,
   output logic             sig_out,
   output logic             busy,
   output logic [CNT_W-1:0] pulse_cnt
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_DELAY = 3'd1;
   localparam logic [2:0] ST_HIGH1 = 3'd2;
   localparam logic [2:0] ST_GAP   = 3'd3;
   localparam logic [2:0] ST_HIGH2 = 3'd4;
   localparam logic [2:0] ST_WAIT  = 3'd5;

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [2:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             stop_pend_reg, stop_pend_next;
   logic [CNT_W-1:0] delay_reg, period_reg, width_reg, interval_reg;
   logic             double_reg;
   logic             sig_out_reg, cfg_err_reg;
   logic [CNT_W-1:0] pulse_cnt_reg;

   logic             idle, cfg_take, cfg_ok, start_take, cnt_done, sig_next;
   logic [CNT_W:0]   iw_sum;

   assign idle       = (state_reg == ST_IDLE);
   assign cfg_take   = cfg_valid && idle;
   assign start_take = idle && start && !stop && !cfg_take;
   assign cnt_done   = (cnt_reg == '0);
   assign sig_next   = (state_reg == ST_HIGH1) || (state_reg == ST_HIGH2);
   assign iw_sum     = {1'b0, cfg_interval} + {1'b0, cfg_width};

   // Config legality: width nonzero, and every derived gap/wait lasts >= 1 cycle.
   always_comb begin
      cfg_ok = (cfg_width != '0);
      if (cfg_double)
         cfg_ok = cfg_ok && (cfg_interval > cfg_width) && ({1'b0, cfg_period} > iw_sum);
      else
         cfg_ok = cfg_ok && (cfg_period > cfg_width);
   end

   // Next-state and counter reload; each state lasts (loaded count + 1) cycles.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      stop_pend_next = stop_pend_reg;
      case (state_reg)
         ST_IDLE: begin
            stop_pend_next = 1'b0;
            if (start_take) begin
               if (delay_reg == '0) begin
                  state_next = ST_HIGH1;
                  cnt_next   = width_reg - ONE;
               end else begin
                  state_next = ST_DELAY;
                  cnt_next   = delay_reg - ONE;
               end
            end
         end
         ST_DELAY, ST_GAP, ST_WAIT: begin
            if (stop) begin
               state_next = ST_IDLE;
            end else if (cnt_done) begin
               state_next = (state_reg == ST_GAP) ? ST_HIGH2 : ST_HIGH1;
               cnt_next   = width_reg - ONE;
            end else begin
               cnt_next = cnt_reg - ONE;
            end
         end
         ST_HIGH1, ST_HIGH2: begin
            if (cnt_done) begin
               if (stop || stop_pend_reg) begin
                  state_next = ST_IDLE;
               end else if (state_reg == ST_HIGH1 && double_reg) begin
                  state_next = ST_GAP;
                  cnt_next   = interval_reg - width_reg - ONE;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = (state_reg == ST_HIGH2)
                             ? period_reg - interval_reg - width_reg - ONE
                             : period_reg - width_reg - ONE;
               end
            end else begin
               cnt_next = cnt_reg - ONE;
               if (stop) stop_pend_next = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM state, counter and pending-stop flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         stop_pend_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         stop_pend_reg <= stop_pend_next;
      end
   end

   // Configuration registers and the one-cycle reject flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         delay_reg    <= DEF_DELAY;
         period_reg   <= DEF_PERIOD;
         width_reg    <= DEF_WIDTH;
         interval_reg <= DEF_INTERVAL;
         double_reg   <= 1'b0;
         cfg_err_reg  <= 1'b0;
      end else begin
         cfg_err_reg <= cfg_take && !cfg_ok;
         if (cfg_take && cfg_ok) begin
            delay_reg    <= cfg_delay;
            period_reg   <= cfg_period;
            width_reg    <= cfg_width;
            interval_reg <= cfg_interval;
            double_reg   <= cfg_double;
         end
      end
   end

   // Registered pulse output and saturating leading-edge counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_out_reg   <= 1'b0;
         pulse_cnt_reg <= '0;
      end else begin
         sig_out_reg <= sig_next;
         if (start_take)
            pulse_cnt_reg <= '0;
         else if (sig_next && !sig_out_reg && pulse_cnt_reg != CNT_MAX)
            pulse_cnt_reg <= pulse_cnt_reg + ONE;
      end
   end

   assign cfg_ready = idle;
   assign busy      = !idle;
   assign cfg_err   = cfg_err_reg;
   assign sig_out   = sig_out_reg;
   assign pulse_cnt = pulse_cnt_reg;

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// tb_pulse_train_ctrl: directed stimulus; expected pulse edges/widths and cfg_err
// cycles are queued by the stimulus thread and consumed by a negedge monitor.
module tb_pulse_train_ctrl;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_delay = '0, cfg_period = '0, cfg_width = '0, cfg_interval = '0;
   logic             cfg_double = 1'b0;
   logic             cfg_err;
   logic             start = 1'b0, stop = 1'b0;
   logic             sig_out, busy;
   logic [CNT_W-1:0] pulse_cnt;

   pulse_train_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_delay(cfg_delay), .cfg_period(cfg_period), .cfg_width(cfg_width),
      .cfg_interval(cfg_interval), .cfg_double(cfg_double), .cfg_err(cfg_err),
      .start(start), .stop(stop), .sig_out(sig_out), .busy(busy), .pulse_cnt(pulse_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;   // number of rising edges so far
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int rise; int width; } exp_pulse_t;
   exp_pulse_t exp_q[$];
   int         exp_err_q[$];
   int         compared = 0;
   int         mismatched = 0;

   task automatic check(input string name, input longint act, input longint exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
      end
   endtask

   // Monitor: rising edge of sig_out pops an expected pulse; falling edge checks width.
   logic       prev_sig = 1'b0;
   bit         in_pulse = 1'b0;
   int         width_seen = 0;
   exp_pulse_t cur;
   always @(negedge clk) begin
      if (sig_out && !prev_sig) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse_rise", cyc, -1);
            in_pulse = 1'b0;
         end else begin
            cur = exp_q.pop_front();
            check("pulse_rise_cycle", cyc, cur.rise);
            in_pulse = 1'b1;
         end
         width_seen = 1;
      end else if (sig_out) begin
         width_seen++;
      end else if (prev_sig && in_pulse) begin
         check("pulse_width", width_seen, cur.width);
         in_pulse = 1'b0;
      end
      prev_sig = sig_out;
      if (cfg_err) begin
         if (exp_err_q.size() == 0) check("unexpected_cfg_err", cyc, -1);
         else check("cfg_err_cycle", cyc, exp_err_q.pop_front());
      end
   end

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic do_start(output int e);
      start = 1'b1; e = cyc + 1; @(negedge clk); start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1; @(negedge clk); stop = 1'b0;
   endtask

   // Offer a config for one edge (optionally with start); queue cfg_err if rejection expected.
   task automatic do_cfg(input int d, input int p, input int w, input int i, input bit dbl,
                         input bit with_start, input bit exp_err, output int e);
      cfg_delay = CNT_W'(d); cfg_period = CNT_W'(p); cfg_width = CNT_W'(w);
      cfg_interval = CNT_W'(i); cfg_double = dbl;
      cfg_valid = 1'b1; start = with_start; e = cyc + 1;
      if (exp_err) exp_err_q.push_back(e);
      @(negedge clk);
      cfg_valid = 1'b0; start = 1'b0;
   endtask

   task automatic push_pulse(input int rise, input int w);
      exp_pulse_t p;
      p.rise = rise; p.width = w;
      exp_q.push_back(p);
   endtask

   initial begin
      int e0, e;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // Reset state
      check("rst_sig_out", sig_out, 0);
      check("rst_busy", busy, 0);
      check("rst_pulse_cnt", pulse_cnt, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_cfg_ready", cfg_ready, 1);

      // Defaults D=0 P=100 W=2: rises after edges 1,101,201
      do_start(e0);
      push_pulse(e0 + 1, 2); push_pulse(e0 + 101, 2); push_pulse(e0 + 201, 2);
      wait_until(e0 + 50);
      check("t1_busy_mid", busy, 1);
      check("t1_cfg_ready_mid", cfg_ready, 0);
      wait_until(e0 + 201);
      check("t1_pulse_cnt", pulse_cnt, 3);
      check("t1_busy", busy, 1);
      // Stop on first high cycle: pulse still 2 cycles, busy drops next edge
      do_stop();
      check("t4_busy_after_stop", busy, 0);
      check("t4_sig_still_high", sig_out, 1);
      repeat (20) @(negedge clk);
      check("t4_pulse_cnt_held", pulse_cnt, 3);

      // Double mode D=3 P=20 W=2 I=5
      do_cfg(3, 20, 2, 5, 1, 0, 0, e);
      do_start(e0);
      push_pulse(e0 + 4, 2);  push_pulse(e0 + 9, 2);
      push_pulse(e0 + 24, 2); push_pulse(e0 + 29, 2);
      push_pulse(e0 + 44, 2); push_pulse(e0 + 49, 2);
      wait_until(e0 + 49);
      check("t2_pulse_cnt", pulse_cnt, 6);
      wait_until(e0 + 52);
      do_stop();   // sampled in WAIT
      check("t2_busy_after_stop", busy, 0);
      repeat (20) @(negedge clk);

      // Rejected configs keep previous timing
      do_cfg(0, 50, 0, 5, 0, 0, 1, e);
      @(negedge clk);
      do_cfg(0, 7, 2, 5, 1, 0, 1, e);
      @(negedge clk);
      do_start(e0);
      push_pulse(e0 + 4, 2);  push_pulse(e0 + 9, 2);
      push_pulse(e0 + 24, 2); push_pulse(e0 + 29, 2);
      wait_until(e0 + 31);
      do_stop();
      check("t3_pulse_cnt", pulse_cnt, 4);
      repeat (5) @(negedge clk);

      // Stop during DELAY: no pulses, counter cleared by start
      do_start(e0);
      do_stop();
      check("t4_delay_stop_busy", busy, 0);
      check("t4_delay_stop_cnt", pulse_cnt, 0);
      repeat (30) @(negedge clk);

      // Config + start on the same edge: config applied, start ignored
      do_cfg(0, 10, 3, 5, 0, 1, 0, e);
      check("t6_busy_stays_low", busy, 0);
      do_start(e0);
      push_pulse(e0 + 1, 3); push_pulse(e0 + 11, 3); push_pulse(e0 + 21, 3);
      wait_until(e0 + 24);
      do_stop();
      check("t6_pulse_cnt", pulse_cnt, 3);
      repeat (5) @(negedge clk);

      // Asynchronous reset mid-pulse
      do_start(e0);
      push_pulse(e0 + 1, 1);
      wait_until(e0 + 1);
      #1 rst_n = 1'b0;
      #1;
      check("t5_rst_sig_out", sig_out, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_pulse_cnt", pulse_cnt, 0);
      check("t5_rst_cfg_ready", cfg_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // Defaults restored; cfg offers while busy are ignored silently
      do_start(e0);
      push_pulse(e0 + 1, 2); push_pulse(e0 + 101, 2);
      wait_until(e0 + 10);
      do_cfg(0, 50, 0, 5, 0, 0, 0, e);
      wait_until(e0 + 20);
      do_cfg(0, 10, 1, 5, 0, 0, 0, e);
      wait_until(e0 + 101);
      check("t5_pulse_cnt", pulse_cnt, 2);
      do_stop();
      repeat (10) @(negedge clk);
      check("end_busy", busy, 0);
      check("end_pulses_left", exp_q.size(), 0);
      check("end_cfg_err_left", exp_err_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
